ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares one port of the dual-port data RAM (16-bit words, 10-bit address, synchronous read) between two requesters: r0 = CPU load/store unit, r1 = I/O / display fetch engine.
- Provides round-robin arbitration with optional bounded burst locking, a write path, and a tagged read-return pipeline that routes RAM read data back to the requester that issued it.
- Sits between the requesters and the RAM; the other RAM port is untouched.

Parameters:
- DATA_WIDTH, 16, RAM word width.
- ADDR_WIDTH, 10, RAM word address width.
- READ_LATENCY, 1, cycles from address presented to valid ram_q; legal values 1..4.
- MAX_HOLD, 8, maximum consecutive grants to a locked owner while the other side is requesting; legal values 1..255.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- r0_req, r1_req  in  1 each  access request, held until granted.
- r0_lock, r1_lock  in  1 each  request to keep ownership on following cycles (burst).
- r0_we, r1_we  in  1 each  1 = write, 0 = read.
- r0_addr, r1_addr  in  ADDR_WIDTH each  word address.
- r0_wdata, r1_wdata  in  DATA_WIDTH each  write data.
- r0_gnt, r1_gnt  out  1 each  access accepted this cycle (combinational).
- r0_rvalid, r1_rvalid  out  1 each  read data valid for that requester.
- rdata  out  DATA_WIDTH  read data, shared by both requesters and qualified by rX_rvalid.
- ram_addr  out  ADDR_WIDTH  to RAM port address.
- ram_data  out  DATA_WIDTH  to RAM port write data.
- ram_we  out  1  to RAM port write enable.
- ram_q  in  DATA_WIDTH  RAM port read data.

Behaviour:
- **Handshake:** a transfer occurs in a cycle where rX_req and rX_gnt are both 1. Requesters hold req, we, addr and wdata stable until they are granted. At most one gnt is asserted per cycle. Gnt is never asserted without the matching req.
- **State:**
  - last (1 bit): the most recent winner; reset value 1, so r0 wins first.
  - owner_locked (1 bit), reset value 0.
  - hold_cnt (8 bits), reset value 0.
  - read pipe: READ_LATENCY stages of {valid, id}, all stages invalid at reset.
- **Grant selection, combinational, evaluated in order:**
  - (a) rst_n = 0: no grant.
  - (b) owner_locked = 1, the owner is still requesting, and either the other side is idle or hold_cnt < MAX_HOLD: grant the owner.
  - (c) Both requesting: grant the requester that is not last.
  - (d) Exactly one requesting: grant it.
  - (e) Neither requesting: no grant.
- **Update on a granted cycle:**
  - last <= winner.
  - owner_locked <= winner's lock.
  - hold_cnt <= hold_cnt+1 (saturating) if the winner equals the previous owner and owner_locked was 1; otherwise hold_cnt <= 1.
- **Update on a cycle with no grant:** owner_locked <= 0 and hold_cnt <= 0. Lock is released whenever the owner drops req.
- **Starvation bound:** after MAX_HOLD consecutive locked grants with the other side requesting, rule (b) fails and rule (c) grants the other side, because last = owner. The other side therefore waits at most MAX_HOLD cycles.
- **RAM drive:**
  - ram_addr and ram_data follow the winner's addr and wdata.
  - ram_we = (granted winner's we).
  - With no grant: ram_we = 0 and ram_addr/ram_data hold r0's values; these are don't-care but must be deterministic.
- **Read return:**
  - A granted read pushes {1, id} into stage 0; each stage shifts every cycle.
  - rX_rvalid = last stage valid and id == X. This gives exactly READ_LATENCY cycles from grant to rvalid.
  - rdata = ram_q, passed through combinationally.
  - Granted writes push invalid entries into the pipe and never produce rvalid.
  - Back-to-back reads from alternating requesters return in issue order, one per cycle.
- **Reset:**
  - rst_n low mid-operation clears the pipe; in-flight reads are dropped and no rvalid is emitted after reset.
  - While rst_n is low: gnt = 0 and ram_we = 0.
  - All registers take their reset values on the first edge with rst_n low.
- **Simultaneous events:**
  - A requester dropping req in the same cycle another raises it is handled by rules (c)/(d) for that cycle.
  - Lock asserted together with we = 1 is legal (burst write).

Decomposition:
- Shared package ram_arb_pkg:
  - requester ID constants REQ_CPU = 0 and REQ_IO = 1.
  - localparam width of hold_cnt (8).
  - a typedef for the read-pipe entry {valid, id}.
- One natural sub-module, ram_rd_tag_pipe: a parameterised READ_LATENCY shift pipe of {valid, id} with synchronous active-low clear. Arbitration logic stays in the top module.

Test Plan:
- **Single read:** r0 read, addr 0x005, with RAM preloaded 0x005 = 0xBEEF. Expect r0_gnt in cycle 0, ram_we = 0, and r0_rvalid = 1 with rdata = 0xBEEF in cycle READ_LATENCY. r1_rvalid stays 0.
- **Contention:** both requesting continuous reads from cycle 0 onward. Expect grants r0, r1, r0, r1…, and rvalid alternating r0/r1 each cycle after the latency, with data matching each address.
- **Lock and starvation bound:** r1 locked burst write, addrs 0x100–0x10F, with r0 requesting from the second grant onward, MAX_HOLD = 8. Expect r1 to get 8 consecutive grants, then r0 granted on the next cycle, then r1 resumes. Readback of 0x100–0x107 matches the written data.
- **Write then read same address:** r1 writes 0x1234 to 0x3FF, then r0 reads 0x3FF on the next cycle. Expect r0 rdata = 0x1234 and no rvalid for the write.
- **Reset mid-flight:** READ_LATENCY = 2, r0 read granted, rst_n pulled low on the next edge. Expect no r0_rvalid afterwards. After release, the first contended grant goes to r0.
- **Idle:** no requests for 10 cycles. Expect all gnt = 0, ram_we = 0, and all rvalid = 0 throughout.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter and its read-tag pipe.
package ram_arb_pkg;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_IO  = 1'b1;

  localparam int HOLD_W = 8;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Fixed-depth shift pipe carrying {valid, id} tags alongside the RAM read latency.
module ram_rd_tag_pipe
  import ram_arb_pkg::*;
#(
  parameter int STAGES = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t push,
  output rd_tag_t tail
);

  rd_tag_t [STAGES-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= push;
      for (int i = 1; i < STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign tail = vld_pipe[STAGES-1];

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter with bounded burst locking sharing one RAM port between
// the CPU (r0) and the I/O fetch engine (r1); read data is routed back by tag.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int MAX_HOLD     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r1_req,
  input  logic                  r0_lock,
  input  logic                  r1_lock,
  input  logic                  r0_we,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  r0_rvalid,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [1:0]        req, lock, we;
  logic              last_q, locked_q;
  logic [HOLD_W-1:0] hold_q;
  logic              gnt_any, win;
  rd_tag_t           push, tail;

  assign req  = {r1_req, r0_req};
  assign lock = {r1_lock, r0_lock};
  assign we   = {r1_we, r0_we};

  // The locked owner is always the last winner, so last_q doubles as owner id.
  always_comb begin
    gnt_any = 1'b0;
    win     = REQ_CPU;
    if (rst_n) begin
      if (locked_q && req[last_q] && (!req[~last_q] || hold_q < HOLD_MAX)) begin
        gnt_any = 1'b1;
        win     = last_q;
      end else if (req[0] && req[1]) begin
        gnt_any = 1'b1;
        win     = ~last_q;
      end else if (req[0]) begin
        gnt_any = 1'b1;
        win     = REQ_CPU;
      end else if (req[1]) begin
        gnt_any = 1'b1;
        win     = REQ_IO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q   <= REQ_IO;
      locked_q <= 1'b0;
      hold_q   <= '0;
    end else if (gnt_any) begin
      last_q   <= win;
      locked_q <= lock[win];
      if (locked_q && win == last_q)
        hold_q <= (hold_q == '1) ? hold_q : hold_q + 1'b1;
      else
        hold_q <= HOLD_W'(1);
    end else begin
      locked_q <= 1'b0;
      hold_q   <= '0;
    end
  end

  assign r0_gnt = gnt_any && (win == REQ_CPU);
  assign r1_gnt = gnt_any && (win == REQ_IO);

  // Idle cycles leave win at REQ_CPU, so the RAM sees r0's address/data.
  assign ram_addr = (win == REQ_IO) ? r1_addr : r0_addr;
  assign ram_data = (win == REQ_IO) ? r1_wdata : r0_wdata;
  assign ram_we   = gnt_any && we[win];

  assign push = {gnt_any && !we[win], win};

  ram_rd_tag_pipe #(
    .STAGES(READ_LATENCY)
  ) u_rd_pipe (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .tail (tail)
  );

  assign r0_rvalid = tail.valid && (tail.id == REQ_CPU);
  assign r1_rvalid = tail.valid && (tail.id == REQ_IO);
  assign rdata     = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised bench for ram_port_arbiter with a behavioural RAM and a
// transaction-level model of arbitration and read return.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 16;
  localparam int AW = 10;
  localparam int RL = 2;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic r0_req = 0, r1_req = 0, r0_lock = 0, r1_lock = 0, r0_we = 0, r1_we = 0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_we;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;

  int n_chk = 0;
  int n_err = 0;

  ram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r1_req(r1_req), .r0_lock(r0_lock), .r1_lock(r1_lock),
    .r0_we(r0_we), .r1_we(r1_we), .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37) ^ 16'h5A5A;
  endfunction

  // Behavioural synchronous RAM with RL cycles of read latency and a backdoor.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] qp [RL];
  logic bk_init = 0, bk_we = 0;
  logic [AW-1:0] bk_addr = '0;
  logic [DW-1:0] bk_data = '0;

  always @(posedge clk) begin
    if (bk_init) for (int i = 0; i < (1<<AW); i++) mem[i] <= init_val(i);
    else if (ram_we) mem[ram_addr] <= ram_data;
    else if (bk_we) mem[bk_addr] <= bk_data;
    qp[0] <= mem[ram_addr];
    for (int i = 1; i < RL; i++) qp[i] <= qp[i-1];
  end
  assign ram_q = qp[RL-1];

  // Reference model: who wins by the arbitration rules, and a queue of
  // expected read returns stamped with the cycle they are due.
  typedef struct {int due; int id; logic [DW-1:0] data;} ret_t;
  ret_t rq[$];
  logic [DW-1:0] shadow [1<<AW];
  int cyc = 0, m_last = 1, m_hold = 0;
  bit m_locked = 0;

  function automatic bit req_of(input int i);  return i ? r1_req  : r0_req;  endfunction
  function automatic bit lock_of(input int i); return i ? r1_lock : r0_lock; endfunction
  function automatic bit we_of(input int i);   return i ? r1_we   : r0_we;   endfunction
  function automatic logic [AW-1:0] addr_of(input int i);  return i ? r1_addr  : r0_addr;  endfunction
  function automatic logic [DW-1:0] wdata_of(input int i); return i ? r1_wdata : r0_wdata; endfunction

  function automatic int exp_win();
    if (!rst_n) return -1;
    if (m_locked && req_of(m_last) && (!req_of(1 - m_last) || m_hold < MH)) return m_last;
    if (r0_req && r1_req) return 1 - m_last;
    if (r0_req) return 0;
    if (r1_req) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] gvec(input int w);
    return (w < 0) ? 2'b00 : (w == 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic bit exp_rv(input int id);
    return rq.size() > 0 && rq[0].due == cyc && rq[0].id == id;
  endfunction

  function automatic logic [DW-1:0] exp_rd();
    return (rq.size() > 0) ? rq[0].data : '0;
  endfunction

  always @(posedge clk) begin
    int w;
    if (bk_init) for (int i = 0; i < (1<<AW); i++) shadow[i] = init_val(i);
    if (!rst_n) begin
      m_last = 1; m_locked = 0; m_hold = 0;
      rq.delete();
    end else begin
      w = exp_win();
      if (w >= 0) begin
        m_hold = (m_locked && m_last == w) ? ((m_hold < 255) ? m_hold + 1 : 255) : 1;
        m_locked = lock_of(w);
        m_last = w;
        if (we_of(w)) shadow[addr_of(w)] = wdata_of(w);
        else rq.push_back('{cyc + RL, w, shadow[addr_of(w)]});
      end else begin
        m_locked = 0; m_hold = 0;
        if (bk_we) shadow[bk_addr] = bk_data;
      end
    end
    cyc++;
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
  end

  task automatic drv(input int i, input bit rq_, input bit lk, input bit w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (i == 0) begin r0_req = rq_; r0_lock = lk; r0_we = w; r0_addr = a; r0_wdata = d; end
    else        begin r1_req = rq_; r1_lock = lk; r1_we = w; r1_addr = a; r1_wdata = d; end
  endtask

  task automatic do_reset();
    drv(0, 0, 0, 0, '0, '0); drv(1, 0, 0, 0, '0, '0);
    rst_n = 0; @(negedge clk); rst_n = 1;
  endtask

  task automatic test_reset();
    drv(0, 1, 1, 1, 10'h001, 16'h1111); drv(1, 1, 0, 1, 10'h002, 16'h2222);
    bk_init = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bk_init = 0; #1;
      n_chk++;
      if ({r1_gnt, r0_gnt, ram_we, r1_rvalid, r0_rvalid} !== 5'b0) begin
        n_err++; $display("FAIL reset_outputs k=%0d got=%b exp=00000", k,
                          {r1_gnt, r0_gnt, ram_we, r1_rvalid, r0_rvalid});
      end
    end
    drv(0, 0, 0, 0, '0, '0); drv(1, 0, 0, 0, '0, '0);
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_single_read();
    bk_we = 1; bk_addr = 10'h005; bk_data = 16'hBEEF;
    @(negedge clk); bk_we = 0;
    drv(0, 1, 0, 0, 10'h005, 16'h0);
    for (int k = 0; k <= RL + 2; k++) begin
      #1;
      n_chk++;
      if (r0_gnt !== (k == 0) || r1_gnt !== 1'b0 || ram_we !== 1'b0) begin
        n_err++; $display("FAIL single_gnt k=%0d got g0=%b g1=%b we=%b exp g0=%b g1=0 we=0",
                          k, r0_gnt, r1_gnt, ram_we, k == 0);
      end
      n_chk++;
      if (r0_rvalid !== (k == RL) || r1_rvalid !== 1'b0) begin
        n_err++; $display("FAIL single_rvalid k=%0d got rv0=%b rv1=%b exp rv0=%b rv1=0",
                          k, r0_rvalid, r1_rvalid, k == RL);
      end
      if (k == RL) begin
        n_chk++;
        if (rdata !== 16'hBEEF) begin
          n_err++; $display("FAIL single_rdata got=%h exp=beef", rdata);
        end
      end
      @(negedge clk);
      if (k == 0) drv(0, 0, 0, 0, '0, '0);
    end
  endtask

  task automatic test_contention();
    int w;
    do_reset();
    drv(0, 1, 0, 0, AW'($urandom), '0); drv(1, 1, 0, 0, AW'($urandom), '0);
    for (int k = 0; k < 20; k++) begin
      #1; w = exp_win();
      n_chk++;
      if ({r1_gnt, r0_gnt} !== ((k % 2) ? 2'b10 : 2'b01) || {r1_gnt, r0_gnt} !== gvec(w)) begin
        n_err++; $display("FAIL contention_gnt k=%0d got=%b exp=%b", k, {r1_gnt, r0_gnt},
                          (k % 2) ? 2'b10 : 2'b01);
      end
      n_chk++;
      if (r0_rvalid !== (k >= RL && (k - RL) % 2 == 0) || r1_rvalid !== (k >= RL && (k - RL) % 2 == 1) ||
          r0_rvalid !== exp_rv(0) || r1_rvalid !== exp_rv(1)) begin
        n_err++; $display("FAIL contention_rvalid k=%0d got=%b%b exp=%b%b", k, r1_rvalid, r0_rvalid,
                          exp_rv(1), exp_rv(0));
      end
      if (exp_rv(0) || exp_rv(1)) begin
        n_chk++;
        if (rdata !== exp_rd()) begin
          n_err++; $display("FAIL contention_rdata k=%0d got=%h exp=%h", k, rdata, exp_rd());
        end
      end
      @(negedge clk);
      if (w == 0) r0_addr = AW'($urandom);
      if (w == 1) r1_addr = AW'($urandom);
    end
    drv(0, 0, 0, 0, '0, '0); drv(1, 0, 0, 0, '0, '0);
    repeat (RL + 1) @(negedge clk);
  endtask

  task automatic test_lock_starvation();
    int w, n = 0, exp_w;
    bit r0_done = 0;
    logic [DW-1:0] wd [16];
    for (int k = 0; k < 20; k++) begin
      if (n < 16) drv(1, 1, 1, 1, AW'(10'h100 + n), DW'($urandom)); else drv(1, 0, 0, 0, '0, '0);
      if (k >= 1 && !r0_done) drv(0, 1, 0, 0, 10'h200, '0); else drv(0, 0, 0, 0, '0, '0);
      #1; w = exp_win();
      exp_w = (k < 8) ? 1 : (k == 8) ? 0 : (k <= 16) ? 1 : -1;
      n_chk++;
      if ({r1_gnt, r0_gnt} !== gvec(exp_w) || {r1_gnt, r0_gnt} !== gvec(w)) begin
        n_err++; $display("FAIL lock_gnt k=%0d got=%b exp=%b", k, {r1_gnt, r0_gnt}, gvec(exp_w));
      end
      if (w == 1) begin wd[n] = r1_wdata; n++; end
      if (w == 0) r0_done = 1;
      @(negedge clk);
    end
    for (int k = 0; k < 8 + RL; k++) begin
      if (k < 8) drv(0, 1, 0, 0, AW'(10'h100 + k), '0); else drv(0, 0, 0, 0, '0, '0);
      #1;
      if (k >= RL) begin
        n_chk++;
        if (r0_rvalid !== 1'b1 || rdata !== wd[k - RL] || rdata !== exp_rd()) begin
          n_err++; $display("FAIL lock_readback idx=%0d got rv=%b data=%h exp rv=1 data=%h",
                            k - RL, r0_rvalid, rdata, wd[k - RL]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_write_read();
    for (int k = 0; k <= RL + 3; k++) begin
      if (k == 0) drv(1, 1, 0, 1, 10'h3FF, 16'h1234); else drv(1, 0, 0, 0, '0, '0);
      if (k == 1) drv(0, 1, 0, 0, 10'h3FF, '0); else drv(0, 0, 0, 0, '0, '0);
      #1;
      if (k == 0) begin
        n_chk++;
        if (r1_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 10'h3FF || ram_data !== 16'h1234) begin
          n_err++; $display("FAIL wr_drive got g1=%b we=%b a=%h d=%h exp g1=1 we=1 a=3ff d=1234",
                            r1_gnt, ram_we, ram_addr, ram_data);
        end
      end
      n_chk++;
      if (r1_rvalid !== 1'b0 || r0_rvalid !== (k == 1 + RL)) begin
        n_err++; $display("FAIL wr_rvalid k=%0d got rv0=%b rv1=%b exp rv0=%b rv1=0",
                          k, r0_rvalid, r1_rvalid, k == 1 + RL);
      end
      if (k == 1 + RL) begin
        n_chk++;
        if (rdata !== 16'h1234) begin
          n_err++; $display("FAIL wr_rdata got=%h exp=1234", rdata);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    drv(0, 1, 0, 0, 10'h010, '0); drv(1, 0, 0, 0, '0, '0);
    for (int k = 0; k < 7; k++) begin
      #1;
      if (k == 0) begin
        n_chk++;
        if (r0_gnt !== 1'b1) begin n_err++; $display("FAIL midflight_gnt got=%b exp=1", r0_gnt); end
      end
      if (k == 1 || k == 2) begin
        n_chk++;
        if ({r1_gnt, r0_gnt, ram_we} !== 3'b0) begin
          n_err++; $display("FAIL midflight_in_reset k=%0d got=%b exp=000", k, {r1_gnt, r0_gnt, ram_we});
        end
      end
      if (k == 3) begin
        n_chk++;
        if ({r1_gnt, r0_gnt} !== 2'b01) begin
          n_err++; $display("FAIL midflight_first_after_reset got=%b exp=01", {r1_gnt, r0_gnt});
        end
      end
      n_chk++;
      if ({r1_rvalid, r0_rvalid} !== {exp_rv(1), exp_rv(0)} || (k >= 1 && k <= 4 && (r0_rvalid || r1_rvalid))) begin
        n_err++; $display("FAIL midflight_rvalid k=%0d got=%b%b exp=%b%b", k, r1_rvalid, r0_rvalid,
                          exp_rv(1), exp_rv(0));
      end
      @(negedge clk);
      if (k == 0) begin rst_n = 0; drv(0, 1, 0, 1, 10'h011, 16'hAAAA); drv(1, 1, 0, 1, 10'h012, 16'hBBBB); end
      if (k == 2) begin rst_n = 1; drv(0, 1, 0, 0, 10'h020, '0); drv(1, 1, 0, 0, 10'h021, '0); end
    end
    drv(0, 0, 0, 0, '0, '0); drv(1, 0, 0, 0, '0, '0);
    repeat (RL + 1) @(negedge clk);
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      #1;
      n_chk++;
      if ({r1_gnt, r0_gnt, ram_we, r1_rvalid, r0_rvalid} !== 5'b0) begin
        n_err++; $display("FAIL idle k=%0d got=%b exp=00000", k, {r1_gnt, r0_gnt, ram_we, r1_rvalid, r0_rvalid});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    int w, wt0 = 0, wt1 = 0;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 2; i++)
        if (!req_of(i) && $urandom_range(0, 9) < 6)
          drv(i, 1, $urandom_range(0, 9) < 4, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 31)), DW'($urandom));
      #1; w = exp_win();
      n_chk++;
      if ({r1_gnt, r0_gnt} !== gvec(w)) begin
        n_err++; $display("FAIL random_gnt k=%0d got=%b exp=%b", k, {r1_gnt, r0_gnt}, gvec(w));
      end
      if (w >= 0) begin
        n_chk++;
        if (ram_we !== we_of(w) || ram_addr !== addr_of(w) || ram_data !== wdata_of(w)) begin
          n_err++; $display("FAIL random_ram k=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h", k,
                            ram_we, ram_addr, ram_data, we_of(w), addr_of(w), wdata_of(w));
        end
      end
      n_chk++;
      if ({r1_rvalid, r0_rvalid} !== {exp_rv(1), exp_rv(0)}) begin
        n_err++; $display("FAIL random_rvalid k=%0d got=%b%b exp=%b%b", k, r1_rvalid, r0_rvalid,
                          exp_rv(1), exp_rv(0));
      end
      if (exp_rv(0) || exp_rv(1)) begin
        n_chk++;
        if (rdata !== exp_rd()) begin
          n_err++; $display("FAIL random_rdata k=%0d got=%h exp=%h", k, rdata, exp_rd());
        end
      end
      wt0 = (r0_req && w != 0) ? wt0 + 1 : 0;
      wt1 = (r1_req && w != 1) ? wt1 + 1 : 0;
      if (r0_req || r1_req) begin
        n_chk++;
        if (wt0 > MH || wt1 > MH) begin
          n_err++; $display("FAIL random_starve k=%0d got wait0=%0d wait1=%0d exp<=%0d", k, wt0, wt1, MH);
        end
      end
      @(negedge clk);
      if (w >= 0) drv(w, 0, 0, 0, '0, '0);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_lock_starvation();
    test_write_read();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
